spi_reg_bank: RTL and testbench
===============================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter DATA_W, default 8, width of each register and of the SPI data field.
REQ-002 Parameter ADDR_W, default 7, width of the SPI address field.
REQ-003 Parameter NUM_REGS, default 5, number of implemented registers (1..2^ADDR_W).
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth (>=2) for sclk, copi, ncs.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sclk  in  1  SPI clock from controller, asynchronous to clk.
REQ-008 copi  in  1  SPI data from controller.
REQ-009 ncs  in  1  SPI chip select, active low.
REQ-010 cipo  out  1  SPI read data to controller.
REQ-011 cipo_oe  out  1  cipo drive enable; high while synchronised ncs is low.
REQ-012 regs_flat  out  NUM_REGS*DATA_W  register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-013 wr_strobe  out  NUM_REGS  one-cycle pulse on bit i when register i is written.
REQ-014 err_pulse  out  1  one-cycle pulse when a frame is rejected.
REQ-015 err_count  out  8  count of rejected frames, saturating at 255.

Function
REQ-016 SPI mode 0: sample copi on sclk rising edge, update cipo on sclk falling edge, MSB first.
REQ-017 Frame = FRAME_W = 1+ADDR_W+DATA_W bits: R/W bit (1=write), address, data.
REQ-018 Edges detected from the last two synchroniser stages; sclk high/low phases >= SYNC_STAGES+2 clk cycles required.
REQ-019 FSM states: IDLE, CMD, DATA, WAIT_END.
REQ-020 IDLE -> CMD on synchronised ncs falling edge; bit counter and shift register cleared.
REQ-021 CMD: shift 1+ADDR_W bits; after the last address bit -> DATA.
REQ-022 DATA: shift DATA_W bits; after the last data bit -> WAIT_END.
REQ-023 Any further sclk rising edge in WAIT_END marks the frame overrun.
REQ-024 Synchronised ncs rising edge from any state -> IDLE and triggers frame evaluation.
REQ-025 Write committed only if exactly FRAME_W bits received, R/W=1 and address < NUM_REGS.
REQ-026 Commit: register and wr_strobe bit update one clk after the ncs rising edge is detected.
REQ-027 Rejected frame (short, overrun, or address >= NUM_REGS, read or write): no register change, err_pulse for one cycle, err_count incremented unless 255.
REQ-028 A complete, valid read frame modifies nothing and raises no error.
REQ-029 Read: on CMD->DATA with R/W=0, load out-shifter with register[address] (0 if address >= NUM_REGS); cipo = its MSB within one clk.
REQ-030 Each subsequent sclk falling edge in DATA shifts the next bit onto cipo; cipo = 0 in IDLE, CMD, WAIT_END and for write frames.
REQ-031 An sclk edge detected in the same cycle as an ncs rising edge is ignored.
REQ-032 An ncs falling edge with no preceding rising edge (glitch) restarts the frame in CMD with counter cleared.
REQ-033 Register contents change only through committed writes.

Reset
REQ-034 rst_n low clears immediately: FSM IDLE, counters, shift registers, synchronisers to ncs=1/sclk=0/copi=0, all regs_flat 0, wr_strobe 0, err_pulse 0, err_count 0, cipo 0, cipo_oe 0.
REQ-035 Reset asserted mid-frame discards the frame; the first frame after release starts only on a new ncs falling edge.

Verification
REQ-036 Write 16-bit frame 0x80A5 (W, addr 0, 0xA5) -> regs_flat[7:0]=0xA5, wr_strobe=5'b00001 for one clk, err_count=0.
REQ-037 Write addr 2 data 0x3C, then read frame 0x0200 -> cipo bits 0,0,1,1,1,1,0,0 during data phase, registers unchanged.
REQ-038 Write frame 0x8577 (addr 5) -> no register change, err_pulse once, err_count=1.
REQ-039 Frames of 10 bits and 17 bits with W, addr 1, data 0xFF -> register 1 stays 0, err_count=2.
REQ-040 Assert rst_n low after 9 bits of 0x81FF -> all outputs 0; next full 0x81FF -> register 1 = 0xFF.
REQ-041 Send 260 short frames -> err_count saturates at 255, err_pulse on every frame.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a small bank of write/read registers.
// Latency: commit/error one clk after synchronised ncs rise; read MSB on cipo one clk after the command completes.
// Backpressure: none; the SPI controller paces frames and clk must oversample sclk by >= SYNC_STAGES+2 per phase.
module spi_reg_bank #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       err_pulse,
    output logic [7:0]                 err_count
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    // sclk/ncs chains carry one history flop past the synchroniser for edge detection
    localparam int HIST    = SYNC_STAGES + 1;

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(ADDR_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_END} state_t;

    logic [HIST-1:0]        sclk_s, ncs_s, vld_s;
    logic [SYNC_STAGES-1:0] copi_s;
    logic                   sclk_cur, sclk_prv, ncs_cur, ncs_prv, copi_cur, hist_vld;
    logic                   ncs_rise, ncs_fall, sclk_rise, sclk_fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_W-1:0]     shreg, shift_in;
    logic [DATA_W-1:0]      out_sh;
    logic                   overrun;

    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      rd_data;
    logic [ADDR_W-1:0]      cmd_addr, fr_addr;
    logic [DATA_W-1:0]      fr_data;
    logic                   fr_rw, addr_ok, frame_full, frame_end, wr_commit, frame_err;

    // Input synchronisers; vld_s marks stages holding real samples so reset values never fake an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= '0;
            ncs_s  <= '1;
            copi_s <= '0;
            vld_s  <= '0;
        end else begin
            sclk_s <= {sclk_s[HIST-2:0], sclk};
            ncs_s  <= {ncs_s[HIST-2:0], ncs};
            copi_s <= {copi_s[SYNC_STAGES-2:0], copi};
            vld_s  <= {vld_s[HIST-2:0], 1'b1};
        end
    end

    assign sclk_cur  = sclk_s[SYNC_STAGES-1];
    assign sclk_prv  = sclk_s[SYNC_STAGES];
    assign ncs_cur   = ncs_s[SYNC_STAGES-1];
    assign ncs_prv   = ncs_s[SYNC_STAGES];
    assign copi_cur  = copi_s[SYNC_STAGES-1];
    assign hist_vld  = vld_s[SYNC_STAGES];

    // sclk edges coinciding with the end of a frame are dropped
    assign ncs_rise  = hist_vld &  ncs_cur & ~ncs_prv;
    assign ncs_fall  = hist_vld & ~ncs_cur &  ncs_prv;
    assign sclk_rise = hist_vld &  sclk_cur & ~sclk_prv & ~ncs_rise;
    assign sclk_fall = hist_vld & ~sclk_cur &  sclk_prv & ~ncs_rise;

    assign shift_in  = {shreg[FRAME_W-2:0], copi_cur};
    assign cmd_addr  = shift_in[ADDR_W-1:0];
    assign fr_rw     = shreg[FRAME_W-1];
    assign fr_addr   = shreg[DATA_W +: ADDR_W];
    assign fr_data   = shreg[DATA_W-1:0];

    // Read mux for the address just completed on the wire; unimplemented addresses read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(cmd_addr) == i) rd_data = regs_q[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: ncs edges override everything, a fall mid-frame restarts the command
    always_comb begin
        state_d = state_q;
        if (ncs_rise) begin
            state_d = IDLE;
        end else if (ncs_fall) begin
            state_d = CMD;
        end else begin
            case (state_q)
                CMD:     if (sclk_rise && bit_cnt == CMD_LAST)  state_d = DATA;
                DATA:    if (sclk_rise && bit_cnt == DATA_LAST) state_d = WAIT_END;
                default: ;
            endcase
        end
    end

    // FSM outputs: cipo only carries read data while in the data phase
    always_comb begin
        cipo    = (state_q == DATA) ? out_sh[DATA_W-1] : 1'b0;
        cipo_oe = ~ncs_cur;
    end

    // Frame datapath: bit counter, input shifter, overrun flag, read out-shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            overrun <= 1'b0;
            out_sh  <= '0;
        end else if (ncs_fall) begin
            bit_cnt <= '0;
            shreg   <= '0;
            overrun <= 1'b0;
            out_sh  <= '0;
        end else if (sclk_rise && (state_q == CMD || state_q == DATA)) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (state_q == CMD && bit_cnt == CMD_LAST)
                out_sh <= shift_in[ADDR_W] ? '0 : rd_data;
        end else if (sclk_rise && state_q == WAIT_END) begin
            overrun <= 1'b1;
        end else if (sclk_fall && state_q == DATA && bit_cnt != DATA_FIRST) begin
            // the falling edge right after loading would skip the MSB, so shifting starts one edge later
            out_sh <= {out_sh[DATA_W-2:0], 1'b0};
        end
    end

    assign addr_ok    = 32'(fr_addr) < NUM_REGS;
    assign frame_end  = ncs_rise && (state_q != IDLE);
    assign frame_full = (bit_cnt == FRAME_FULL) && !overrun;
    assign wr_commit  = frame_end && frame_full && addr_ok && fr_rw;
    assign frame_err  = frame_end && !(frame_full && addr_ok);

    // Frame evaluation at end of frame: commit write, pulse strobe or error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            wr_strobe <= '0;
            err_pulse <= frame_err;
            if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_commit && 32'(fr_addr) == i) begin
                    regs_q[i]    <= fr_data;
                    wr_strobe[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed register frames plus random frames against a frame-level model.
// Latency: results checked a fixed number of clks after each frame ends.
// Backpressure: none; the bench acts as SPI controller with 8-clk sclk phases.
module tb_spi_reg_bank;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int NR = 5;
    localparam int FW = 1 + AW + DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk = 1'b0;
    logic              copi = 1'b0;
    logic              ncs = 1'b1;
    logic              cipo, cipo_oe;
    logic [NR*DW-1:0]  regs_flat;
    logic [NR-1:0]     wr_strobe;
    logic              err_pulse;
    logic [7:0]        err_count;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_regs [NR];
    int            model_err;
    int            ep_cnt = 0;
    int            ws_cnt [NR];
    logic [31:0]   cap;

    spi_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .copi      (copi),
        .ncs       (ncs),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < NR; i++) ws_cnt[i] = 0;

    // Pulse counters, sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_pulse) ep_cnt = ep_cnt + 1;
            for (int i = 0; i < NR; i++) if (wr_strobe[i]) ws_cnt[i] = ws_cnt[i] + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hp();
        repeat (8) @(posedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic [31:0] w;
        w = v;
        for (int i = 0; i < n; i++) begin
            copi = w[n-1-i];
            hp();
            cap = {cap[30:0], cipo};
            sclk = 1'b1;
            hp();
            sclk = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        model_err = 0;
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model_regs[i];
        return f;
    endfunction

    // One complete frame: drive it, predict it from the frame rules, compare everything observable
    task automatic frame_and_check(input logic [31:0] v, input int n);
        int          e0;
        int          w0 [NR];
        bit          exp_err;
        logic [NR-1:0] exp_ws;
        logic [DW-1:0] exp_rd;
        logic [31:0] w;
        int          a;
        w = v;
        e0 = ep_cnt;
        for (int i = 0; i < NR; i++) w0[i] = ws_cnt[i];

        exp_err = 1'b0;
        exp_ws  = '0;
        exp_rd  = '0;
        if (n == FW) begin
            a = int'(w[FW-2:DW]);
            if (a < NR) begin
                if (w[FW-1]) exp_ws[a] = 1'b1;
                else         exp_rd = model_regs[a];
            end else begin
                exp_err = 1'b1;
            end
        end else begin
            exp_err = 1'b1;
        end

        cap = '0;
        ncs = 1'b0;
        hp();
        send_bits(v, n);
        hp();
        @(negedge clk);
        chk("cipo_oe_active", 64'(cipo_oe), 64'd1);
        ncs = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);

        if (n == FW && w[FW-1] && exp_ws != '0) model_regs[int'(w[FW-2:DW])] = w[DW-1:0];
        if (exp_err && model_err < 255) model_err++;

        chk("regs_flat", 64'(regs_flat), 64'(model_flat()));
        chk("err_count", 64'(err_count), 64'(model_err));
        chk("err_pulses", 64'(ep_cnt - e0), 64'(exp_err));
        for (int i = 0; i < NR; i++)
            chk($sformatf("wr_strobe_%0d", i), 64'(ws_cnt[i] - w0[i]), 64'(exp_ws[i]));
        if (n == FW) chk("cipo_bits", 64'(cap[FW-1:0]), {48'h0, 8'h00, exp_rd});
        chk("cipo_idle", 64'(cipo), 64'd0);
        chk("cipo_oe_idle", 64'(cipo_oe), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_regs"}, 64'(regs_flat), 64'd0);
        chk({tag, "_strobe"}, 64'(wr_strobe), 64'd0);
        chk({tag, "_errp"}, 64'(err_pulse), 64'd0);
        chk({tag, "_errc"}, 64'(err_count), 64'd0);
        chk({tag, "_cipo"}, 64'(cipo), 64'd0);
        chk({tag, "_oe"}, 64'(cipo_oe), 64'd0);
    endtask

    initial begin
        logic [31:0] v;
        int          n, r;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        logic        rw;

        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all_zero("post_reset");

        // Write 0xA5 to register 0
        frame_and_check(32'h80A5, FW);
        // Write register 2, then read it back
        frame_and_check(32'h823C, FW);
        frame_and_check(32'h0200, FW);
        // Write to unimplemented address 5
        frame_and_check(32'h8577, FW);
        // Short and overlong frames targeting register 1
        frame_and_check(32'h81FF >> 6, 10);
        frame_and_check({15'h0, 16'h81FF, 1'b1}, 17);
        // Read of unimplemented address
        frame_and_check(32'h0600, FW);

        // Reset in the middle of a frame
        ncs = 1'b0;
        hp();
        send_bits(32'h81FF >> 7, 9);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_frame_reset");
        model_reset();
        ncs = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        frame_and_check(32'h81FF, FW);

        // Random frames, mostly complete, some short or long
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            rw = 1'($urandom_range(0, 1));
            ad = AW'($urandom_range(0, 7));
            dt = DW'($urandom);
            if (r < 7) begin
                n = FW;
                v = {16'h0, rw, ad, dt};
            end else if (r == 7) begin
                n = $urandom_range(1, FW - 1);
                v = $urandom;
            end else begin
                n = $urandom_range(FW + 1, FW + 3);
                v = $urandom;
            end
            frame_and_check(v, n);
        end

        // Enough short frames to saturate the error counter
        for (int k = 0; k < 260; k++) frame_and_check(32'h2, 2);
        chk("err_saturated", 64'(err_count), 64'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
